spi_ahb_loader: RTL
===================

// Module: spi_ahb_loader
// PURPOSE
// - SPI-slave to AHB-lite master bridge; the initiator that drives the router's spi_h* slave port.
// - Host shifts 72-bit frames over SPI to write/read instruction RAM, data RAM and registers.
// - A RUN command pulses SPI_change so the router leaves SPI mode; the loader then goes inert.
// PARAMETERS
// SYNC_STAGES    2        synchroniser depth on spi_sclk/spi_cs_n/spi_mosi (min 2)
// HPROT_VAL      4'b0011  constant hprot driven on every transfer
// PORTS
// clk         in   1   system clock; must be >= 4x spi_sclk
// reset       in   1   synchronous, active-high
// spi_sclk    in   1   SPI clock, mode 0 (sample rising, shift falling), async to clk
// spi_cs_n    in   1   frame select, active-low
// spi_mosi    in   1   serial in, MSB first
// spi_miso    out  1   serial out, MSB first
// spi_haddr   out  32  AHB address, bits [1:0] forced 0
// spi_hwrite  out  1   1=write
// spi_hsize   out  3   constant 3'b010 (word)
// spi_hburst  out  3   constant 3'b000 (SINGLE)
// spi_hmastlock out 1  constant 0
// spi_hprot   out  4   constant HPROT_VAL
// spi_htrans  out  2   2'b00 IDLE / 2'b10 NONSEQ
// spi_hwdata  out  32  write data, valid in data phase
// spi_hrdata  in   32  read data
// spi_hready  in   1   transfer-complete / phase-advance
// spi_hresp   in   1   1=ERROR
// SPI_change  out  1   one-cycle pulse on RUN command
// BEHAVIOUR
// - Reset: htrans=00, haddr=0, hwrite=0, hwdata=0, miso=0, SPI_change=0, run=0, err=0, ovr=0, last_rdata=0, FSM=IDLE, bit count=0.
// - Frame (72 bits, CS low): cmd[7:0], addr[31:0], data[31:0]. cmd 8'h01 WRITE, 8'h02 READ, 8'h03 RUN; others ignored.
// - Edges detected on synchronised sclk; mosi sampled on rising, miso updated on falling.
// - CS falling loads TX shifter {status[7:0], last_rdata[31:0], 32'h0}; status = {5'b0, ovr, err, run}.
// - CS rising before 72 bits: frame discarded, counter cleared, no AHB activity. Bits beyond 72 ignored.
// - 72nd rising edge completes frame; decoded the following clk cycle.
// - Accepted only if FSM==IDLE and run==0; if FSM busy -> dropped, ovr=1 (sticky). If run==1 -> dropped silently.
// - FSM IDLE -> ADDR: htrans=NONSEQ, haddr/hwrite driven. Stay ADDR while hready=0.
// - ADDR -> DATA on hready=1: htrans=IDLE, hwdata=data (writes). Stay DATA while hready=0.
// - DATA -> IDLE on hready=1: reads capture hrdata into last_rdata; hresp=1 sets err (sticky), hrdata not captured.
// - Zero-wait transfer: NONSEQ for exactly 1 cycle, data phase 1 cycle; 2 cycles from decode to IDLE.
// - RUN: SPI_change=1 for exactly one cycle, run=1 (sticky); no AHB transfer.
// - Flags ovr/err/run clear only on reset. Reset mid-transfer: htrans=IDLE next cycle, transfer abandoned.
// STRUCTURE
// - Package spi_ahb_pkg: CMD_WRITE/CMD_READ/CMD_RUN, HTRANS_IDLE/NONSEQ, HSIZE_WORD, HBURST_SINGLE, FRAME_BITS=72, FSM state encodings.
// - Sub-module spi_slave_shifter: synchronisers, edge detect, 72-bit RX/TX shift, bit counter, frame_done/frame_abort strobes.
// - Top: command decode, AHB FSM (IDLE/ADDR/DATA), status flags.
// TESTING
// - WRITE 01_00004004_DEADBEEF, hready=1 -> 1 cycle NONSEQ haddr=0x00004004 hwrite=1, next cycle hwdata=0xDEADBEEF, htrans=00.
// - READ 02_00000010, hrdata=0x12345678; next frame -> first 40 miso bits = 0x00_12345678.
// - WRITE with hready low 3 cycles in ADDR and 2 in DATA -> signals held stable, single transfer only.
// - CS raised after 40 bits -> no htrans activity; next full frame processed normally.
// - Frame completes while FSM in DATA (hready held low) -> dropped, status ovr=1; hresp=1 on read -> err=1, last_rdata unchanged.
// - RUN 03_... -> SPI_change high exactly 1 cycle; later WRITE produces no transfer; reset asserted mid-ADDR -> htrans=00 next cycle, flags cleared.

Source files
------------

// File: rtl/spi_ahb_pkg.sv
// rtl/spi_ahb_pkg.sv - shared constants, types and helpers for the SPI-to-AHB loader
package spi_ahb_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_RUN   = 8'h03;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam int                FRAME_BITS = 72;
  localparam int                CNT_W      = 7;
  localparam logic [CNT_W-1:0]  FRAME_CNT  = 7'(FRAME_BITS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } ahb_state_e;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
  } frame_t;

  function automatic logic [7:0] status_byte(input logic ovr, input logic err, input logic run);
    return {5'b0, ovr, err, run};
  endfunction

endpackage

// File: rtl/spi_ahb_loader_if.sv
// rtl/spi_ahb_loader_if.sv - AHB-lite master-side bus bundle driven by the loader
interface spi_ahb_loader_if;

  logic [31:0] spi_haddr;
  logic        spi_hwrite;
  logic [2:0]  spi_hsize;
  logic [2:0]  spi_hburst;
  logic        spi_hmastlock;
  logic [3:0]  spi_hprot;
  logic [1:0]  spi_htrans;
  logic [31:0] spi_hwdata;
  logic [31:0] spi_hrdata;
  logic        spi_hready;
  logic        spi_hresp;

  modport master (
    output spi_haddr, spi_hwrite, spi_hsize, spi_hburst, spi_hmastlock,
           spi_hprot, spi_htrans, spi_hwdata,
    input  spi_hrdata, spi_hready, spi_hresp
  );

  modport slave (
    input  spi_haddr, spi_hwrite, spi_hsize, spi_hburst, spi_hmastlock,
           spi_hprot, spi_htrans, spi_hwdata,
    output spi_hrdata, spi_hready, spi_hresp
  );

endinterface

// File: rtl/spi_slave_shifter.sv
// rtl/spi_slave_shifter.sv - SPI mode-0 slave: synchronisers, 72-bit RX/TX shift, frame strobes
module spi_slave_shifter
  import spi_ahb_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        spi_sclk_i,
  input  logic        spi_cs_n_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  input  logic [39:0] tx_head_i,
  output frame_t      frame_o,
  output logic        frame_done_o,
  output logic        frame_abort_o
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic [FRAME_BITS-1:0]  rx_q, rx_d, tx_q, tx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   miso_q, miso_d;
  logic                   done_q, done_d, abort_q, abort_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  always_comb begin
    rx_d    = rx_q;
    tx_d    = tx_q;
    cnt_d   = cnt_q;
    miso_d  = miso_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    if (cs_fall) begin
      // MSB must be on miso before the host's first rising edge
      tx_d   = {tx_head_i, 32'h0};
      miso_d = tx_head_i[39];
      cnt_d  = '0;
    end else if (cs_rise) begin
      abort_d = (cnt_q != FRAME_CNT);
      cnt_d   = '0;
    end else if (!cs_s) begin
      if (sclk_rise && (cnt_q < FRAME_CNT)) begin
        rx_d   = {rx_q[FRAME_BITS-2:0], mosi_s};
        cnt_d  = cnt_q + 7'd1;
        done_d = (cnt_q == FRAME_CNT - 7'd1);
      end
      if (sclk_fall) begin
        tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
        miso_d = tx_q[FRAME_BITS-2];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      rx_q        <= '0;
      tx_q        <= '0;
      cnt_q       <= '0;
      miso_q      <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      cnt_q       <= cnt_d;
      miso_q      <= miso_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
    end
  end

  assign spi_miso_o    = miso_q;
  assign frame_o       = frame_t'(rx_q);
  assign frame_done_o  = done_q;
  assign frame_abort_o = abort_q;

endmodule

// File: rtl/spi_ahb_loader.sv
// rtl/spi_ahb_loader.sv - SPI-slave to AHB-lite master bridge with command decode and status flags
module spi_ahb_loader
  import spi_ahb_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [3:0] HPROT_VAL   = 4'b0011
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              SPI_change,
  spi_ahb_loader_if.master  ahb
);

  frame_t frame;
  logic   frame_done, frame_abort, frame_valid;

  ahb_state_e  state_q, state_d;
  logic [31:0] haddr_q, haddr_d;
  logic        hwrite_q, hwrite_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ovr_q, ovr_d, err_q, err_d, run_q, run_d;
  logic        change_q, change_d;

  spi_slave_shifter #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_shifter (
    .clk_i         (clk),
    .reset_i       (reset),
    .spi_sclk_i    (spi_sclk),
    .spi_cs_n_i    (spi_cs_n),
    .spi_mosi_i    (spi_mosi),
    .spi_miso_o    (spi_miso),
    .tx_head_i     ({status_byte(ovr_q, err_q, run_q), rdata_q}),
    .frame_o       (frame),
    .frame_done_o  (frame_done),
    .frame_abort_o (frame_abort)
  );

  assign frame_valid = frame_done & ~frame_abort;

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    wdata_d  = wdata_q;
    hwdata_d = hwdata_q;
    rdata_d  = rdata_q;
    ovr_d    = ovr_q;
    err_d    = err_q;
    run_d    = run_q;
    change_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_valid && !run_q) begin
          case (frame.cmd)
            CMD_WRITE, CMD_READ: begin
              state_d  = ST_ADDR;
              haddr_d  = frame.addr & ~32'h3;
              hwrite_d = (frame.cmd == CMD_WRITE);
              wdata_d  = frame.data;
            end
            CMD_RUN: begin
              change_d = 1'b1;
              run_d    = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_ADDR: begin
        if (ahb.spi_hready) begin
          state_d = ST_DATA;
          if (hwrite_q) hwdata_d = wdata_q;
        end
      end
      ST_DATA: begin
        if (ahb.spi_hready) begin
          state_d = ST_IDLE;
          if (ahb.spi_hresp) err_d = 1'b1;
          else if (!hwrite_q) rdata_d = ahb.spi_hrdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A frame arriving mid-transfer is lost; once running, frames are ignored without trace
    if (frame_valid && !run_q && (state_q != ST_IDLE)) ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      wdata_q  <= '0;
      hwdata_q <= '0;
      rdata_q  <= '0;
      ovr_q    <= 1'b0;
      err_q    <= 1'b0;
      run_q    <= 1'b0;
      change_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      wdata_q  <= wdata_d;
      hwdata_q <= hwdata_d;
      rdata_q  <= rdata_d;
      ovr_q    <= ovr_d;
      err_q    <= err_d;
      run_q    <= run_d;
      change_q <= change_d;
    end
  end

  assign ahb.spi_haddr     = haddr_q;
  assign ahb.spi_hwrite    = hwrite_q;
  assign ahb.spi_hsize     = HSIZE_WORD;
  assign ahb.spi_hburst    = HBURST_SINGLE;
  assign ahb.spi_hmastlock = 1'b0;
  assign ahb.spi_hprot     = HPROT_VAL;
  assign ahb.spi_htrans    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahb.spi_hwdata    = hwdata_q;
  assign SPI_change        = change_q;

endmodule
